// File: rtl/wb_to_bus_bridge.sv
// Wishbone classic (B3) slave to valid/ready split-bus initiator bridge.
// Each Wishbone cycle becomes exactly one read or write transaction on the
// bus. Only one transaction is ever outstanding. If the master drops wb_cyc
// mid-transaction, the bus side still runs to completion, because the bus
// cannot cancel. The bridge then returns to IDLE silently, with no ack or err.
module wb_to_bus_bridge #(
    parameter int addr_width   = 32,
    parameter int data_width   = 32,
    parameter int strobe_width = data_width / 8,
    parameter int resp_width   = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [addr_width-1:0]   wb_adr,
    input  logic [data_width-1:0]   wb_datwr,
    output logic [data_width-1:0]   wb_datrd,
    input  logic                    wb_we,
    input  logic                    wb_stb,
    input  logic                    wb_cyc,
    input  logic [strobe_width-1:0] wb_sel,
    output logic                    wb_ack,
    output logic                    wb_err,
    output logic                    bus_r_addr_valid,
    input  logic                    bus_r_addr_ready,
    output logic [addr_width-1:0]   bus_r_addr,
    input  logic                    bus_r_data_valid,
    output logic                    bus_r_data_ready,
    input  logic [data_width-1:0]   bus_r_data,
    output logic                    bus_w_data_addr_valid,
    input  logic                    bus_w_data_addr_ready,
    output logic [addr_width-1:0]   bus_w_addr,
    output logic [data_width-1:0]   bus_w_data,
    output logic [strobe_width-1:0] bus_w_strobe,
    input  logic                    bus_w_resp_valid,
    output logic                    bus_w_resp_ready,
    input  logic [resp_width-1:0]   bus_w_resp
);

    localparam logic [resp_width-1:0] RESP_OKAY = resp_width'(1'b1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_REQ  = 3'd3,
        WR_RESP = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic                    abort_q, abort_d;
    logic                    ack_q, ack_d;
    logic                    err_q, err_d;
    logic                    r_valid_q, r_valid_d;
    logic                    r_ready_q, r_ready_d;
    logic                    w_valid_q, w_valid_d;
    logic                    b_ready_q, b_ready_d;
    logic [addr_width-1:0]   addr_q, addr_d;
    logic [data_width-1:0]   wdata_q, wdata_d;
    logic [strobe_width-1:0] strobe_q, strobe_d;
    logic [data_width-1:0]   rdata_q, rdata_d;

    // Next-state and next-output logic; registers hold unless a transition updates them.
    always_comb begin
        state_d   = state_q;
        abort_d   = abort_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        r_valid_d = r_valid_q;
        r_ready_d = r_ready_q;
        w_valid_d = w_valid_q;
        b_ready_d = b_ready_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        strobe_d  = strobe_q;
        rdata_d   = rdata_q;
        case (state_q)
            IDLE: begin
                if (wb_cyc && wb_stb) begin
                    addr_d  = wb_adr;
                    abort_d = 1'b0;
                    if (wb_we) begin
                        wdata_d   = wb_datwr;
                        strobe_d  = wb_sel;
                        w_valid_d = 1'b1;
                        state_d   = WR_REQ;
                    end else begin
                        r_valid_d = 1'b1;
                        state_d   = RD_ADDR;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RD_ADDR: begin
                abort_d = abort_q | ~wb_cyc;
                if (bus_r_addr_ready) begin
                    r_valid_d = 1'b0;
                    r_ready_d = 1'b1;
                    state_d   = RD_DATA;
                end else begin
                    state_d = RD_ADDR;
                end
            end
            RD_DATA: begin
                abort_d = abort_q | ~wb_cyc;
                if (bus_r_data_valid) begin
                    rdata_d   = bus_r_data;
                    r_ready_d = 1'b0;
                    if (abort_d) begin
                        state_d = IDLE;
                    end else begin
                        ack_d   = 1'b1;
                        state_d = DONE;
                    end
                end else begin
                    state_d = RD_DATA;
                end
            end
            WR_REQ: begin
                abort_d = abort_q | ~wb_cyc;
                if (bus_w_data_addr_ready) begin
                    w_valid_d = 1'b0;
                    b_ready_d = 1'b1;
                    state_d   = WR_RESP;
                end else begin
                    state_d = WR_REQ;
                end
            end
            WR_RESP: begin
                abort_d = abort_q | ~wb_cyc;
                if (bus_w_resp_valid) begin
                    b_ready_d = 1'b0;
                    if (abort_d) begin
                        state_d = IDLE;
                    end else if (bus_w_resp == RESP_OKAY) begin
                        ack_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end else begin
                    state_d = WR_RESP;
                end
            end
            DONE: begin
                // Strobe is deliberately not sampled here so a held stb cannot retrigger.
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                r_valid_d = 1'b0;
                r_ready_d = 1'b0;
                w_valid_d = 1'b0;
                b_ready_d = 1'b0;
            end
        endcase
    end

    // Control registers: state, handshake flags and Wishbone pulses, cleared by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            abort_q   <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            r_valid_q <= 1'b0;
            r_ready_q <= 1'b0;
            w_valid_q <= 1'b0;
            b_ready_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            abort_q   <= abort_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            r_valid_q <= r_valid_d;
            r_ready_q <= r_ready_d;
            w_valid_q <= w_valid_d;
            b_ready_q <= b_ready_d;
        end
    end

    // Datapath registers: address, write payload and read data; reset value is irrelevant.
    always_ff @(posedge clock) begin
        addr_q   <= addr_d;
        wdata_q  <= wdata_d;
        strobe_q <= strobe_d;
        rdata_q  <= rdata_d;
    end

    assign wb_ack                = ack_q;
    assign wb_err                = err_q;
    assign wb_datrd              = rdata_q;
    assign bus_r_addr_valid      = r_valid_q;
    assign bus_r_data_ready      = r_ready_q;
    assign bus_r_addr            = addr_q;
    assign bus_w_data_addr_valid = w_valid_q;
    assign bus_w_addr            = addr_q;
    assign bus_w_data            = wdata_q;
    assign bus_w_strobe          = strobe_q;
    assign bus_w_resp_ready      = b_ready_q;

endmodule

// File: tb/tb_wb_to_bus_bridge.sv
// Self-checking bench for wb_to_bus_bridge: directed scenarios plus a scoreboard
// of expected Wishbone completions compared whenever ack or err pulses.
module tb_wb_to_bus_bridge;

    logic        clock;
    logic        reset;
    logic [31:0] wb_adr;
    logic [31:0] wb_datwr;
    logic [31:0] wb_datrd;
    logic        wb_we;
    logic        wb_stb;
    logic        wb_cyc;
    logic [3:0]  wb_sel;
    logic        wb_ack;
    logic        wb_err;
    logic        bus_r_addr_valid;
    logic        bus_r_addr_ready;
    logic [31:0] bus_r_addr;
    logic        bus_r_data_valid;
    logic        bus_r_data_ready;
    logic [31:0] bus_r_data;
    logic        bus_w_data_addr_valid;
    logic        bus_w_data_addr_ready;
    logic [31:0] bus_w_addr;
    logic [31:0] bus_w_data;
    logic [3:0]  bus_w_strobe;
    logic        bus_w_resp_valid;
    logic        bus_w_resp_ready;
    logic [0:0]  bus_w_resp;

    typedef struct packed {
        logic        is_err;
        logic        chk_data;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   checks;
    int   passes;
    int   rd_hs_cnt;

    wb_to_bus_bridge dut (
        .clock(clock), .reset(reset),
        .wb_adr(wb_adr), .wb_datwr(wb_datwr), .wb_datrd(wb_datrd),
        .wb_we(wb_we), .wb_stb(wb_stb), .wb_cyc(wb_cyc), .wb_sel(wb_sel),
        .wb_ack(wb_ack), .wb_err(wb_err),
        .bus_r_addr_valid(bus_r_addr_valid), .bus_r_addr_ready(bus_r_addr_ready),
        .bus_r_addr(bus_r_addr), .bus_r_data_valid(bus_r_data_valid),
        .bus_r_data_ready(bus_r_data_ready), .bus_r_data(bus_r_data),
        .bus_w_data_addr_valid(bus_w_data_addr_valid),
        .bus_w_data_addr_ready(bus_w_data_addr_ready),
        .bus_w_addr(bus_w_addr), .bus_w_data(bus_w_data), .bus_w_strobe(bus_w_strobe),
        .bus_w_resp_valid(bus_w_resp_valid), .bus_w_resp_ready(bus_w_resp_ready),
        .bus_w_resp(bus_w_resp)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Scoreboard monitor: every completion pulse must match the oldest expectation.
    always @(negedge clock) begin
        if (!reset && bus_r_addr_valid && bus_r_addr_ready) rd_hs_cnt = rd_hs_cnt + 1;
        if (!reset && (wb_ack || wb_err)) begin
            checks = checks + 1;
            if (wb_ack && wb_err) begin
                $display("FAIL ack_err_both: ack=%b err=%b required not both high", wb_ack, wb_err);
            end else if (sb_q.size() == 0) begin
                $display("FAIL unexpected_completion: ack=%b err=%b required none", wb_ack, wb_err);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (wb_err !== e.is_err || wb_ack !== !e.is_err)
                    $display("FAIL sb_kind: ack=%b err=%b required err=%b", wb_ack, wb_err, e.is_err);
                else if (e.chk_data && wb_datrd !== e.data)
                    $display("FAIL sb_data: got %h required %h", wb_datrd, e.data);
                else
                    passes = passes + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_sel = 4'h0;
        wb_adr = 32'h0; wb_datwr = 32'h0;
        bus_r_addr_ready = 1'b0; bus_r_data_valid = 1'b0; bus_r_data = 32'h0;
        bus_w_data_addr_ready = 1'b0; bus_w_resp_valid = 1'b0; bus_w_resp = 1'b1;
    endtask

    // Generic read with an always-ready bus; waits a bounded time for ack.
    task automatic run_read(input logic [31:0] addr, input logic [31:0] data);
        bit got;
        got = 1'b0;
        sb_q.push_back('{is_err: 1'b0, chk_data: 1'b1, data: data});
        wb_adr = addr; wb_we = 1'b0; wb_cyc = 1'b1; wb_stb = 1'b1;
        bus_r_addr_ready = 1'b1; bus_r_data_valid = 1'b1; bus_r_data = data;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (bus_r_addr_valid) begin
                checks++;
                if (bus_r_addr !== addr) $display("FAIL rr_addr: got %h required %h", bus_r_addr, addr);
                else passes++;
            end
            if (wb_ack || wb_err) got = 1'b1;
        end
        checks++;
        if (!got) $display("FAIL rr_timeout: got no ack required ack within 20 cycles");
        else passes++;
        idle_inputs();
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick(); tick();
        checks++;
        if ({wb_ack, wb_err, bus_r_addr_valid, bus_r_data_ready, bus_w_data_addr_valid, bus_w_resp_ready} !== 6'b0)
            $display("FAIL reset_outputs: got %b required 000000",
                {wb_ack, wb_err, bus_r_addr_valid, bus_r_data_ready, bus_w_data_addr_valid, bus_w_resp_ready});
        else passes++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_read_latency();
        sb_q.push_back('{is_err: 1'b0, chk_data: 1'b1, data: 32'hDEADBEEF});
        wb_adr = 32'h100; wb_we = 1'b0; wb_cyc = 1'b1; wb_stb = 1'b1;
        bus_r_addr_ready = 1'b1;
        tick(); // edge 0
        checks++;
        if (bus_r_addr_valid !== 1'b1 || bus_r_addr !== 32'h100 || wb_ack !== 1'b0)
            $display("FAIL rd_req: valid=%b addr=%h ack=%b required 1/100/0", bus_r_addr_valid, bus_r_addr, wb_ack);
        else passes++;
        tick(); // edge 1: address handshake
        checks++;
        if (bus_r_addr_valid !== 1'b0 || bus_r_data_ready !== 1'b1 || wb_ack !== 1'b0)
            $display("FAIL rd_hs: valid=%b rready=%b ack=%b required 0/1/0", bus_r_addr_valid, bus_r_data_ready, wb_ack);
        else passes++;
        bus_r_data_valid = 1'b1; bus_r_data = 32'hDEADBEEF;
        tick(); // edge 2: data handshake, ack in cycle 3
        checks++;
        if (wb_ack !== 1'b1 || wb_datrd !== 32'hDEADBEEF || bus_r_data_ready !== 1'b0)
            $display("FAIL rd_ack: ack=%b data=%h rready=%b required 1/deadbeef/0", wb_ack, wb_datrd, bus_r_data_ready);
        else passes++;
        idle_inputs();
        tick();
        checks++;
        if (wb_ack !== 1'b0) $display("FAIL rd_ack_pulse: ack=%b required 0", wb_ack);
        else passes++;
    endtask

    task automatic test_write_backpressure();
        sb_q.push_back('{is_err: 1'b0, chk_data: 1'b0, data: 32'h0});
        wb_adr = 32'h200; wb_datwr = 32'h12345678; wb_sel = 4'b0011; wb_we = 1'b1;
        wb_cyc = 1'b1; wb_stb = 1'b1;
        bus_w_data_addr_ready = 1'b0;
        tick(); // edge 0
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus_w_data_addr_valid !== 1'b1 || bus_w_addr !== 32'h200 ||
                bus_w_data !== 32'h12345678 || bus_w_strobe !== 4'b0011)
                $display("FAIL wr_hold%0d: valid=%b addr=%h data=%h strb=%b required 1/200/12345678/0011",
                    i, bus_w_data_addr_valid, bus_w_addr, bus_w_data, bus_w_strobe);
            else passes++;
            if (i == 3) bus_w_data_addr_ready = 1'b1;
            tick();
        end
        bus_w_data_addr_ready = 1'b0;
        checks++;
        if (bus_w_data_addr_valid !== 1'b0 || bus_w_resp_ready !== 1'b1)
            $display("FAIL wr_hs: valid=%b bready=%b required 0/1", bus_w_data_addr_valid, bus_w_resp_ready);
        else passes++;
        bus_w_resp_valid = 1'b1; bus_w_resp = 1'b1;
        tick();
        checks++;
        if (wb_ack !== 1'b1 || wb_err !== 1'b0 || bus_w_resp_ready !== 1'b0)
            $display("FAIL wr_ack: ack=%b err=%b bready=%b required 1/0/0", wb_ack, wb_err, bus_w_resp_ready);
        else passes++;
        idle_inputs();
        tick();
        checks++;
        if (wb_ack !== 1'b0) $display("FAIL wr_ack_pulse: ack=%b required 0", wb_ack);
        else passes++;
    endtask

    task automatic test_write_error();
        sb_q.push_back('{is_err: 1'b1, chk_data: 1'b0, data: 32'h0});
        wb_adr = 32'h240; wb_datwr = 32'hA5A5A5A5; wb_sel = 4'h0; wb_we = 1'b1;
        wb_cyc = 1'b1; wb_stb = 1'b1;
        bus_w_data_addr_ready = 1'b1;
        tick();
        checks++;
        if (bus_w_strobe !== 4'h0 || bus_w_data_addr_valid !== 1'b1)
            $display("FAIL we_strobe0: strb=%b valid=%b required 0000/1", bus_w_strobe, bus_w_data_addr_valid);
        else passes++;
        tick();
        bus_w_data_addr_ready = 1'b0;
        bus_w_resp_valid = 1'b1; bus_w_resp = 1'b0;
        tick();
        checks++;
        if (wb_err !== 1'b1 || wb_ack !== 1'b0)
            $display("FAIL we_err: err=%b ack=%b required 1/0", wb_err, wb_ack);
        else passes++;
        idle_inputs();
        tick();
        checks++;
        if ({wb_err, wb_ack, bus_w_data_addr_valid, bus_w_resp_ready} !== 4'b0)
            $display("FAIL we_idle: err/ack/valid/bready=%b required 0000",
                {wb_err, wb_ack, bus_w_data_addr_valid, bus_w_resp_ready});
        else passes++;
    endtask

    task automatic test_held_strobe();
        int hs0;
        bit got;
        hs0 = rd_hs_cnt;
        got = 1'b0;
        sb_q.push_back('{is_err: 1'b0, chk_data: 1'b1, data: 32'h11110001});
        wb_adr = 32'h280; wb_we = 1'b0; wb_cyc = 1'b1; wb_stb = 1'b1;
        bus_r_addr_ready = 1'b1; bus_r_data_valid = 1'b1; bus_r_data = 32'h11110001;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (wb_ack) got = 1'b1;
        end
        checks++;
        if (!got) $display("FAIL hs_ack1: got no ack required ack within 20 cycles");
        else passes++;
        sb_q.push_back('{is_err: 1'b0, chk_data: 1'b1, data: 32'h22220002});
        bus_r_data = 32'h22220002;
        tick(); // leaving DONE with stb still high
        checks++;
        if (bus_r_addr_valid !== 1'b0 || wb_ack !== 1'b0)
            $display("FAIL hs_no_retrigger: valid=%b ack=%b required 0/0", bus_r_addr_valid, wb_ack);
        else passes++;
        tick(); // IDLE samples the held strobe
        checks++;
        if (bus_r_addr_valid !== 1'b1) $display("FAIL hs_second_start: valid=%b required 1", bus_r_addr_valid);
        else passes++;
        wb_stb = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (wb_ack) got = 1'b1;
        end
        checks++;
        if (!got) $display("FAIL hs_ack2: got no ack required ack within 20 cycles");
        else passes++;
        idle_inputs();
        tick(); tick();
        checks++;
        if (rd_hs_cnt - hs0 !== 2) $display("FAIL hs_count: got %0d required 2", rd_hs_cnt - hs0);
        else passes++;
    endtask

    task automatic test_abort();
        wb_adr = 32'h300; wb_we = 1'b0; wb_cyc = 1'b1; wb_stb = 1'b1;
        bus_r_addr_ready = 1'b1;
        tick(); tick(); // now waiting for read data
        wb_cyc = 1'b0; wb_stb = 1'b0; bus_r_addr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus_r_data_ready !== 1'b1 || wb_ack !== 1'b0)
                $display("FAIL ab_wait%0d: rready=%b ack=%b required 1/0", i, bus_r_data_ready, wb_ack);
            else passes++;
        end
        bus_r_data_valid = 1'b1; bus_r_data = 32'hCAFEF00D;
        tick();
        checks++;
        if (bus_r_data_ready !== 1'b0 || wb_ack !== 1'b0 || wb_err !== 1'b0 || wb_datrd !== 32'hCAFEF00D)
            $display("FAIL ab_done: rready=%b ack=%b err=%b data=%h required 0/0/0/cafef00d",
                bus_r_data_ready, wb_ack, wb_err, wb_datrd);
        else passes++;
        idle_inputs();
        tick();
        checks++;
        if (wb_ack !== 1'b0 || wb_err !== 1'b0)
            $display("FAIL ab_silent: ack=%b err=%b required 0/0", wb_ack, wb_err);
        else passes++;
        run_read(32'h304, 32'h0BADF00D);
    endtask

    task automatic test_reset_mid();
        wb_adr = 32'h500; wb_datwr = 32'h77778888; wb_sel = 4'hF; wb_we = 1'b1;
        wb_cyc = 1'b1; wb_stb = 1'b1; bus_w_data_addr_ready = 1'b0;
        tick();
        checks++;
        if (bus_w_data_addr_valid !== 1'b1) $display("FAIL rm_req: valid=%b required 1", bus_w_data_addr_valid);
        else passes++;
        reset = 1'b1;
        tick();
        checks++;
        if ({bus_w_data_addr_valid, wb_ack, bus_w_resp_ready, bus_r_addr_valid} !== 4'b0)
            $display("FAIL rm_clear: valid/ack/bready/rvalid=%b required 0000",
                {bus_w_data_addr_valid, wb_ack, bus_w_resp_ready, bus_r_addr_valid});
        else passes++;
        reset = 1'b0;
        idle_inputs();
        tick();
        run_read(32'h400, 32'h55AA33CC);
    endtask

    // Test sequence and summary.
    initial begin
        checks = 0;
        passes = 0;
        rd_hs_cnt = 0;
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_read_latency();
        test_write_backpressure();
        test_write_error();
        test_held_strobe();
        test_abort();
        test_reset_mid();
        tick(); tick();
        checks++;
        if (sb_q.size() != 0) $display("FAIL sb_empty: got %0d pending required 0", sb_q.size());
        else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/wb_to_bus_bridge.md
Name: wb_to_bus_bridge

Overview:
Wishbone classic (B3, non-pipelined) slave that converts each Wishbone cycle into one transaction on the core's valid/ready split bus, acting as bus initiator. It is the mirror of the bus-to-Wishbone adapter. It lets a Wishbone master (debug host, DMA) reach bus-side memories and peripherals. At most one transaction is outstanding at any time.

Parameters:
addr_width, 32, address width on both sides
data_width, 32, data width on both sides
strobe_width, data_width/8, byte-select / write-strobe width
resp_width, 1, bus write response width; value 1 = OKAY

Ports:
clock  input  1  clock, rising edge
reset  input  1  reset, synchronous, active-high
wb_adr  input  addr_width  Wishbone address
wb_datwr  input  data_width  Wishbone write data
wb_datrd  output  data_width  Wishbone read data, registered
wb_we  input  1  1 = write
wb_stb  input  1  strobe
wb_cyc  input  1  cycle valid
wb_sel  input  strobe_width  byte selects
wb_ack  output  1  transfer complete, one-cycle pulse
wb_err  output  1  write error, one-cycle pulse
bus_r_addr_valid  output  1  read address valid
bus_r_addr_ready  input  1  read address ready
bus_r_addr  output  addr_width  read address
bus_r_data_valid  input  1  read data valid
bus_r_data_ready  output  1  read data ready
bus_r_data  input  data_width  read data
bus_w_data_addr_valid  output  1  write address/data valid
bus_w_data_addr_ready  input  1  write address/data ready
bus_w_addr  output  addr_width  write address
bus_w_data  output  data_width  write data
bus_w_strobe  output  strobe_width  write byte strobes
bus_w_resp_valid  input  1  write response valid
bus_w_resp_ready  output  1  write response ready
bus_w_resp  input  resp_width  write response

Behaviour:
- Reset values: state IDLE; wb_ack, wb_err, every bus_*_valid and bus_*_ready output 0. Data and address registers are don't-care.
- All outputs are registered. Bus handshake completes on a clock edge where valid && ready.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- IDLE: if wb_cyc && wb_stb:
  - Latch wb_adr into bus_r_addr and bus_w_addr.
  - If wb_we: latch wb_datwr into bus_w_data and wb_sel into bus_w_strobe; go to WR_REQ with bus_w_data_addr_valid=1.
  - Else go to RD_ADDR with bus_r_addr_valid=1.
  - Clear the abort flag.
- RD_ADDR: hold bus_r_addr_valid and bus_r_addr stable until ready. On handshake, drop valid and go to RD_DATA with bus_r_data_ready=1.
- RD_DATA: on bus_r_data_valid, capture bus_r_data into wb_datrd, drop ready, go to DONE.
- WR_REQ: hold valid, address, data and strobe until ready. On handshake, go to WR_RESP with bus_w_resp_ready=1.
- WR_RESP: on bus_w_resp_valid, drop ready and go to DONE. Record error if bus_w_resp != 1.
- DONE: lasts exactly one cycle, then IDLE.
  - wb_ack=1 for reads, and for writes with resp==1.
  - wb_err=1 for writes with resp!=1.
  - wb_ack and wb_err are never high together.
  - In DONE, wb_stb is not sampled, so a held strobe cannot retrigger. The next request is sampled in IDLE no earlier than the cycle after DONE.
- Abort: if wb_cyc is low on any edge while in RD_ADDR, RD_DATA, WR_REQ or WR_RESP, set the abort flag.
  - The bus transaction still runs to completion; the bus has no cancel.
  - On completion, go to IDLE instead of DONE with no ack or err. wb_datrd is still updated.
- Latency with ready=1 and response valid on the cycle after the request handshake: stb sampled at edge 0, request handshake at edge 1, response at edge 2, wb_ack high in cycle 3.
- wb_sel=0 on a write is forwarded as-is (strobe 0), not filtered.
- wb_stb without wb_cyc is ignored.
- Reset mid-transaction returns to IDLE immediately and drops all valid/ready outputs. The downstream bus must also be reset.

Test Plan:
- Read: wb_adr=0x100, we=0; bus returns 0xDEADBEEF with ready=1 and one-cycle data latency -> bus_r_addr=0x100; wb_datrd=0xDEADBEEF; wb_ack high exactly one cycle, in cycle 3.
- Write with backpressure: wb_adr=0x200, wb_datwr=0x12345678, sel=4'b0011; bus_w_data_addr_ready low for 3 cycles; resp=1 -> valid held with addr, data and strobe stable for 4 cycles; then wb_ack pulse, wb_err=0.
- Write error: resp=0 -> wb_err single pulse, wb_ack stays 0, FSM returns to IDLE.
- Held strobe: master keeps stb high for 2 cycles after ack -> exactly one bus transaction per ack; the second transaction starts only from IDLE.
- Abort: cyc dropped while in RD_DATA, bus data returned 4 cycles later -> no wb_ack or wb_err, bus_r_data_ready drops after the handshake, next cycle accepted normally.
- Reset in WR_REQ -> next cycle bus_w_data_addr_valid=0, wb_ack=0, state IDLE; a following read completes correctly.
